press_pulse_gen: RTL and testbench
==================================

PRESS_PULSE_GEN -- requirements
Module: press_pulse_gen

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 4, number of consecutive stable synchronized samples needed to accept a press or a release (legal range 1..255).
REQ-002 Port: clk  input  1  system clock; all logic is on posedge clk.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: key  input  1  raw asynchronous button level, 1 = pressed.
REQ-005 Port: enable  input  1  when 0, pulse is forced to 0 and the FSM keeps running.
REQ-006 Port: pulse  output  1  registered, one-cycle-wide press event (drives L or R of the light chain).

Function
REQ-007 key SHALL pass through a 2-flop synchronizer; key_s is the second flop's output.
REQ-008 FSM states SHALL be IDLE, DEB_PRESS, HELD and DEB_RELEASE, with a counter of width $clog2(DEBOUNCE_CYCLES+1).
REQ-009 IDLE: key_s=1 -> DEB_PRESS with count=1; key_s=0 -> stay in IDLE.
REQ-010 DEB_PRESS: key_s=0 -> IDLE with count=0, no pulse; key_s=1 with count=DEBOUNCE_CYCLES -> HELD; otherwise count+1.
REQ-011 HELD: key_s=0 -> DEB_RELEASE with count=1; key_s=1 -> stay in HELD.
REQ-012 DEB_RELEASE: key_s=1 -> HELD, no pulse; key_s=0 with count=DEBOUNCE_CYCLES -> IDLE; otherwise count+1.
REQ-013 pulse SHALL be 1 for exactly the single cycle after the DEB_PRESS->HELD transition, ANDed with enable sampled at that transition.
REQ-014 Latency: key held at 1 from before posedge 0 SHALL give pulse=1 after posedge DEBOUNCE_CYCLES+3 and pulse=0 after the next posedge.
REQ-015 One press (accepted press followed by accepted release) SHALL give exactly one pulse, regardless of how long the key is held.
REQ-016 A held key SHALL NOT re-trigger; a second pulse requires passage through IDLE.
REQ-017 A press accepted while enable=0 SHALL be consumed; raising enable while the key is still held SHALL NOT produce a pulse.
REQ-018 The counter SHALL saturate and never wrap.

Reset
REQ-019 While reset=1: state=IDLE, count=0, both synchronizer flops=0, pulse=0 (LFSR=10'h001 when configured).
REQ-020 Reset asserted mid-debounce or in HELD SHALL abort without a pulse; a key still held after reset deasserts SHALL be treated as a new press, with pulse after REQ-014 latency.

Configuration
REQ-021 Macro CPU_PLAYER_EN defined: add ports cpu_mode (input, 1) and cpu_level (input, 3), plus a 10-bit Fibonacci LFSR (x^10+x^7+1, seed 10'h001) that advances every cycle.
REQ-022 With CPU_PLAYER_EN and cpu_mode=1: key is ignored; pulse = enable & (lfsr[9:7] < cpu_level) & ~pulse_prev, so pulses are never adjacent; cpu_level=0 gives no pulses.
REQ-023 With CPU_PLAYER_EN and cpu_mode=0, and without CPU_PLAYER_EN: behaviour is exactly REQ-007..REQ-018; without the macro the cpu ports and LFSR do not exist.

Structure
REQ-024 Shared package tug_pkg SHALL hold the FSM state enum, the DEBOUNCE_CYCLES default, and the LFSR seed and tap constants.
REQ-025 The synchronizer SHALL be a separate sub-module, input_sync (clk, reset, d, q), reusable for every board input.

Verification
REQ-026 Reset, then key=1 held 20 cycles with DEBOUNCE_CYCLES=4 -> pulse=1 only after posedge 7; zero pulses on all other cycles.
REQ-027 Bounce: key toggles 1,0,1,0 on consecutive cycles, then 0 -> pulse stays 0 and state returns to IDLE.
REQ-028 Press, release glitch of 2 cycles inside HELD, key held again, then clean release -> exactly one pulse in total.
REQ-029 enable=0 during accepted press, enable=1 while key still held -> no pulse; release, then press again -> one pulse.
REQ-030 Reset pulsed at count=2 in DEB_PRESS with key kept at 1 -> no pulse during reset; one pulse DEBOUNCE_CYCLES+3 edges after reset deasserts.
REQ-031 (CPU_PLAYER_EN) cpu_mode=1, cpu_level=0 for 1000 cycles -> 0 pulses; cpu_level=7 -> pulses present and never on adjacent cycles; the pulse pattern is identical across two runs from reset.

Source files
------------

// File: rtl/tug_pkg.sv
// Shared types and constants for the tug-of-war board inputs: button FSM states,
// default debounce depth and the CPU-player LFSR seed/taps.
package tug_pkg;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      DEB_PRESS   = 2'd1,
      HELD        = 2'd2,
      DEB_RELEASE = 2'd3
   } btn_state_t;

   localparam int         DEBOUNCE_DEFAULT = 4;
   localparam logic [9:0] LFSR_SEED        = 10'h001;
   // x^10 + x^7 + 1 -> feedback from bits 9 and 6
   localparam logic [9:0] LFSR_TAPS        = 10'h240;

   function automatic logic [9:0] lfsr_next(input logic [9:0] cur);
      lfsr_next = {cur[8:0], ^(cur & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/input_sync.sv
// Two-flop synchronizer for an asynchronous board input; q is the second flop.
module input_sync (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta_r;

   // synchronizer chain, cleared by synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         meta_r <= 1'b0;
         q      <= 1'b0;
      end else begin
         meta_r <= d;
         q      <= meta_r;
      end
   end

endmodule

// File: rtl/press_pulse_gen.sv
// Debounced button to single-cycle press pulse. Optional CPU player (random pulses
// from a 10-bit LFSR) is built when the macro CPU_PLAYER_EN is defined.
module press_pulse_gen
   import tug_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       key,
   input  logic       enable,
`ifdef CPU_PLAYER_EN
   input  logic       cpu_mode,
   input  logic [2:0] cpu_level,
`endif
   output logic       pulse
);

   localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] DEB_MAX = CW'(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   btn_state_t    state_r;
   btn_state_t    state_nxt_s;
   logic [CW-1:0] count_r;
   logic [CW-1:0] count_nxt_s;
   logic          key_s;
   logic          accept_s;
   logic          press_evt_r;
   logic          press_evt_nxt_s;
   logic          pulse_nxt_s;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      if (v == DEB_MAX) begin
         sat_inc = v;
      end else begin
         sat_inc = v + CNT_ONE;
      end
   endfunction

   input_sync u_key_sync (
      .clk   (clk),
      .reset (reset),
      .d     (key),
      .q     (key_s)
   );

`ifdef CPU_PLAYER_EN
   logic [9:0] lfsr_r;

   // free-running pseudo-random source for the CPU player
   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr_r <= LFSR_SEED;
      end else begin
         lfsr_r <= lfsr_next(lfsr_r);
      end
   end
`endif

   // FSM state, counter and the two-stage press-event pipeline
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= IDLE;
         count_r     <= '0;
         press_evt_r <= 1'b0;
         pulse       <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         count_r     <= count_nxt_s;
         press_evt_r <= press_evt_nxt_s;
         pulse       <= pulse_nxt_s;
      end
   end

   // debounce next-state logic; accept_s marks the DEB_PRESS->HELD transition
   always_comb begin
      state_nxt_s = state_r;
      count_nxt_s = count_r;
      accept_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (key_s) begin
               state_nxt_s = DEB_PRESS;
               count_nxt_s = CNT_ONE;
            end else begin
               count_nxt_s = '0;
            end
         end
         DEB_PRESS: begin
            if (!key_s) begin
               state_nxt_s = IDLE;
               count_nxt_s = '0;
            end else if (count_r == DEB_MAX) begin
               state_nxt_s = HELD;
               count_nxt_s = '0;
               accept_s    = 1'b1;
            end else begin
               count_nxt_s = sat_inc(count_r);
            end
         end
         HELD: begin
            if (!key_s) begin
               state_nxt_s = DEB_RELEASE;
               count_nxt_s = CNT_ONE;
            end else begin
               count_nxt_s = '0;
            end
         end
         DEB_RELEASE: begin
            if (key_s) begin
               state_nxt_s = HELD;
               count_nxt_s = '0;
            end else if (count_r == DEB_MAX) begin
               state_nxt_s = IDLE;
               count_nxt_s = '0;
            end else begin
               count_nxt_s = sat_inc(count_r);
            end
         end
         default: begin
            state_nxt_s = IDLE;
            count_nxt_s = '0;
         end
      endcase
   end

   // enable is captured at acceptance, so a press accepted while disabled is lost
   always_comb begin
      press_evt_nxt_s = accept_s & enable;
      pulse_nxt_s     = press_evt_r;
`ifdef CPU_PLAYER_EN
      if (cpu_mode) begin
         press_evt_nxt_s = 1'b0;
         pulse_nxt_s     = enable & (lfsr_r[9:7] < cpu_level) & ~pulse;
      end else begin
         press_evt_nxt_s = accept_s & enable;
         pulse_nxt_s     = press_evt_r;
      end
`endif
   end

endmodule

// File: tb/tb_press_pulse_gen.sv
// Directed and randomized checks of press_pulse_gen against a run-length debounce model.
module tb_press_pulse_gen;

   localparam int D = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic key = 1'b0;
   logic enable = 1'b1;
   logic pulse;
`ifdef CPU_PLAYER_EN
   logic       cpu_mode = 1'b0;
   logic [2:0] cpu_level = 3'd0;
`endif

   int n_assert = 0;
   int n_fail = 0;
   int seg_pulses = 0;

   // reference model: two-sample input delay, accepted level, disagreement run length
   logic m_d1 = 1'b0;
   logic m_d2 = 1'b0;
   logic m_held = 1'b0;
   int   m_run = 0;
   logic m_evt = 1'b0;
   logic exp_pulse = 1'b0;

   press_pulse_gen #(.DEBOUNCE_CYCLES(D)) dut (
      .clk       (clk),
      .reset     (reset),
      .key       (key),
      .enable    (enable),
`ifdef CPU_PLAYER_EN
      .cpu_mode  (cpu_mode),
      .cpu_level (cpu_level),
`endif
      .pulse     (pulse)
   );

   always #5 clk = ~clk;

   task automatic model_edge(input logic k, input logic en, input logic rst);
      logic ks;
      logic new_evt;
      if (rst) begin
         m_d1 = 1'b0; m_d2 = 1'b0; m_held = 1'b0; m_run = 0;
         m_evt = 1'b0; exp_pulse = 1'b0;
      end else begin
         exp_pulse = m_evt;
         ks = m_d2;
         new_evt = 1'b0;
         if (ks != m_held) begin
            m_run = m_run + 1;
            if (m_run == D + 1) begin
               m_held = ks;
               m_run = 0;
               new_evt = ks & en;
            end
         end else begin
            m_run = 0;
         end
         m_evt = new_evt;
         m_d2 = m_d1;
         m_d1 = k;
      end
   endtask

   task automatic step(input logic k, input logic en, input logic rst);
      key = k; enable = en; reset = rst;
      @(posedge clk);
      model_edge(k, en, rst);
      #1;
      n_assert++;
      assert (pulse === exp_pulse) else begin
         n_fail++;
         $error("FAIL pulse t=%0t observed=%b expected=%b", $time, pulse, exp_pulse);
      end
      if (pulse === 1'b1) seg_pulses++;
   endtask

   task automatic run(input logic k, input logic en, input int n);
      for (int i = 0; i < n; i++) step(k, en, 1'b0);
   endtask

   task automatic check_count(input string tag, input int expected);
      n_assert++;
      assert (seg_pulses === expected) else begin
         n_fail++;
         $error("FAIL %s pulse_count observed=%0d expected=%0d", tag, seg_pulses, expected);
      end
      seg_pulses = 0;
   endtask

`ifdef CPU_PLAYER_EN
   logic pat1 [0:199];
   logic prev_p;

   task automatic cpu_reset();
      key = 1'b0; reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      prev_p = 1'b0;
   endtask
`endif

   initial begin
      // reset state
      run(1'b0, 1'b1, 0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);
      check_count("reset", 0);

      // clean press: pulse one cycle after edge D+3 only
      run(1'b1, 1'b1, 20);
      check_count("clean_press", 1);
      run(1'b0, 1'b1, 12);
      check_count("clean_release", 0);

      // bounce never reaches acceptance
      step(1'b1, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0);
      run(1'b0, 1'b1, 10);
      check_count("bounce", 0);
      run(1'b1, 1'b1, 12);
      check_count("press_after_bounce", 1);
      run(1'b0, 1'b1, 12);

      // release glitch inside HELD does not re-trigger
      run(1'b1, 1'b1, 12);
      run(1'b0, 1'b1, 2);
      run(1'b1, 1'b1, 12);
      run(1'b0, 1'b1, 12);
      check_count("release_glitch", 1);

      // press accepted while disabled is consumed
      run(1'b1, 1'b0, 10);
      run(1'b1, 1'b1, 10);
      run(1'b0, 1'b1, 12);
      check_count("disabled_press", 0);
      run(1'b1, 1'b1, 12);
      run(1'b0, 1'b1, 12);
      check_count("reenabled_press", 1);

      // reset at count=2 in DEB_PRESS, key still held afterwards
      run(1'b1, 1'b1, 4);
      step(1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      check_count("reset_abort", 0);
      run(1'b1, 1'b1, 12);
      check_count("press_after_reset", 1);
      run(1'b0, 1'b1, 12);
      check_count("release_after_reset", 0);

      // randomized bursts with sporadic enable drops and resets
      for (int b = 0; b < 200; b++) begin
         logic lvl;
         int len;
         lvl = 1'($urandom_range(0, 1));
         len = $urandom_range(1, 12);
         for (int j = 0; j < len; j++) begin
            step(lvl, ($urandom_range(0, 9) != 0), ($urandom_range(0, 199) == 0));
         end
      end
      seg_pulses = 0;

`ifdef CPU_PLAYER_EN
      cpu_mode = 1'b1; cpu_level = 3'd0; enable = 1'b1;
      cpu_reset();
      for (int i = 0; i < 1000; i++) begin
         @(posedge clk); #1;
         n_assert++;
         assert (pulse === 1'b0) else begin
            n_fail++;
            $error("FAIL cpu_level0 observed=%b expected=0", pulse);
         end
      end
      cpu_level = 3'd7;
      cpu_reset();
      seg_pulses = 0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #1;
         pat1[i] = pulse;
         if (pulse === 1'b1) seg_pulses++;
         n_assert++;
         assert (!(pulse === 1'b1 && prev_p === 1'b1)) else begin
            n_fail++;
            $error("FAIL cpu_adjacent i=%0d observed=11 expected=not_adjacent", i);
         end
         prev_p = pulse;
      end
      n_assert++;
      assert (seg_pulses > 0) else begin
         n_fail++;
         $error("FAIL cpu_level7 pulses observed=%0d expected=>0", seg_pulses);
      end
      cpu_reset();
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #1;
         n_assert++;
         assert (pulse === pat1[i]) else begin
            n_fail++;
            $error("FAIL cpu_repeat i=%0d observed=%b expected=%b", i, pulse, pat1[i]);
         end
      end
      cpu_mode = 1'b0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
